// File: rtl/fpu_round_arbiter.sv
// Round-robin arbiter that shares one half-precision rounding unit between the
// FMUL/FMADD and FADD/FSUB paths; resolves dynamic rounding mode and accumulates fflags.
module fpu_round_arbiter #(
  parameter int STD = 15,
  parameter int MAN = 9,
  parameter int EXP = 4,
  parameter int W   = 2*MAN+EXP+6
) (
  input  logic           clk,
  input  logic           rst_l,
  input  logic [2:0]     frm,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [W-1:0]   req0_no,
  input  logic [2:0]     req0_rm,
  input  logic           req0_ovf,
  input  logic           req0_sticky,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [W-1:0]   req1_no,
  input  logic [2:0]     req1_rm,
  input  logic           req1_ovf,
  input  logic           req1_sticky,
  output logic [W-1:0]   rnd_no,
  output logic [2:0]     rnd_rm,
  output logic           rnd_ovf,
  output logic           rnd_sticky,
  input  logic [STD:0]   rnd_result,
  input  logic [2:0]     rnd_flags,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [STD:0]   out_no,
  output logic [2:0]     out_flags,
  output logic           out_src,
  output logic           out_illegal,
  input  logic           fflags_clr,
  output logic [2:0]     fflags_acc
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RND = 2'd1, S_OUT = 2'd2} state_t;

  state_t         r_state, w_state_nxt;
  logic           r_last_grant;
  logic           w_can_acc, w_sel1, w_accept, w_hs;
  logic [W-1:0]   w_no;
  logic [2:0]     w_rm;
  logic           w_ovf, w_sticky;
  logic [3:0]     w_res;

  logic [W-1:0]   r_no_p0;
  logic [2:0]     r_rm_p0;
  logic           r_ovf_p0, r_sticky_p0, r_src_p0, r_ill_p0;
  logic [STD:0]   r_no_p1;
  logic [2:0]     r_flags_p1;
  logic           r_src_p1, r_ill_p1;
  logic [2:0]     r_acc;

  // Returns {illegal, mode}; an illegal resolved mode is replaced by RNE (000).
  function automatic logic [3:0] resolve_rm(input logic [2:0] rm, input logic [2:0] dyn);
    logic [2:0] eff;
    eff = (rm == 3'b111) ? dyn : rm;
    if (eff inside {3'b101, 3'b110, 3'b111}) return 4'b1000;
    return {1'b0, eff};
  endfunction

  function automatic logic [2:0] mask_flags(input logic illegal, input logic [2:0] flags);
    return illegal ? 3'b000 : flags;
  endfunction

  always_comb begin
    w_can_acc   = (r_state == S_IDLE) || ((r_state == S_OUT) && out_ready);
    // On a tie the requester that did not win last time is granted.
    w_sel1      = req1_valid && (!req0_valid || !r_last_grant);
    w_accept    = w_can_acc && (req0_valid || req1_valid);
    w_hs        = (r_state == S_OUT) && out_ready;
    req0_ready  = w_can_acc && req0_valid && !w_sel1;
    req1_ready  = w_can_acc && w_sel1;
    w_no        = w_sel1 ? req1_no     : req0_no;
    w_rm        = w_sel1 ? req1_rm     : req0_rm;
    w_ovf       = w_sel1 ? req1_ovf    : req0_ovf;
    w_sticky    = w_sel1 ? req1_sticky : req0_sticky;
    w_res       = resolve_rm(w_rm, frm);
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_RND;
      S_RND:   w_state_nxt = S_OUT;
      S_OUT:   if (out_ready) w_state_nxt = w_accept ? S_RND : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) r_last_grant <= w_sel1;
    end
  end

  // Stage p0: granted operand held for the rounding unit
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_no_p0     <= '0;
      r_rm_p0     <= 3'b000;
      r_ovf_p0    <= 1'b0;
      r_sticky_p0 <= 1'b0;
      r_src_p0    <= 1'b0;
      r_ill_p0    <= 1'b0;
    end else if (w_accept) begin
      r_no_p0     <= w_no;
      r_rm_p0     <= w_res[2:0];
      r_ovf_p0    <= w_ovf;
      r_sticky_p0 <= w_sticky;
      r_src_p0    <= w_sel1;
      r_ill_p0    <= w_res[3];
    end
  end

  // Stage p1: rounded result captured at the end of the RND cycle
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_no_p1    <= '0;
      r_flags_p1 <= 3'b000;
      r_src_p1   <= 1'b0;
      r_ill_p1   <= 1'b0;
    end else if (r_state == S_RND) begin
      r_no_p1    <= rnd_result;
      r_flags_p1 <= mask_flags(r_ill_p0, rnd_flags);
      r_src_p1   <= r_src_p0;
      r_ill_p1   <= r_ill_p0;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_acc <= 3'b000;
    end else if (fflags_clr) begin
      r_acc <= w_hs ? r_flags_p1 : 3'b000;
    end else if (w_hs) begin
      r_acc <= r_acc | r_flags_p1;
    end
  end

  assign rnd_no      = r_no_p0;
  assign rnd_rm      = r_rm_p0;
  assign rnd_ovf     = r_ovf_p0;
  assign rnd_sticky  = r_sticky_p0;
  assign out_valid   = (r_state == S_OUT);
  assign out_no      = r_no_p1;
  assign out_flags   = r_flags_p1;
  assign out_src     = r_src_p1;
  assign out_illegal = r_ill_p1;
  assign fflags_acc  = r_acc;

endmodule

// File: tb/tb_fpu_round_arbiter.sv
// Bench for fpu_round_arbiter: directed vector table, hand sequences for arbitration,
// back-pressure and reset, then randomized traffic against a transaction-level scoreboard.
module tb_fpu_round_arbiter;

  localparam int W = 28;

  logic          clk = 1'b0;
  logic          rst_l;
  logic [2:0]    frm;
  logic          req0_valid, req0_ready, req0_ovf, req0_sticky;
  logic [W-1:0]  req0_no;
  logic [2:0]    req0_rm;
  logic          req1_valid, req1_ready, req1_ovf, req1_sticky;
  logic [W-1:0]  req1_no;
  logic [2:0]    req1_rm;
  logic [W-1:0]  rnd_no;
  logic [2:0]    rnd_rm;
  logic          rnd_ovf, rnd_sticky;
  logic [15:0]   rnd_result;
  logic [2:0]    rnd_flags;
  logic          out_valid, out_ready;
  logic [15:0]   out_no;
  logic [2:0]    out_flags;
  logic          out_src, out_illegal;
  logic          fflags_clr;
  logic [2:0]    fflags_acc;

  fpu_round_arbiter dut (
    .clk(clk), .rst_l(rst_l), .frm(frm),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_no(req0_no), .req0_rm(req0_rm),
    .req0_ovf(req0_ovf), .req0_sticky(req0_sticky),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_no(req1_no), .req1_rm(req1_rm),
    .req1_ovf(req1_ovf), .req1_sticky(req1_sticky),
    .rnd_no(rnd_no), .rnd_rm(rnd_rm), .rnd_ovf(rnd_ovf), .rnd_sticky(rnd_sticky),
    .rnd_result(rnd_result), .rnd_flags(rnd_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_no(out_no), .out_flags(out_flags),
    .out_src(out_src), .out_illegal(out_illegal),
    .fflags_clr(fflags_clr), .fflags_acc(fflags_acc)
  );

  always #5 clk = ~clk;

  // Stand-in rounding unit: result mixes the operand's top bits with mode/ovf/sticky.
  assign rnd_result = rnd_no[W-1 -: 16] ^ {rnd_rm, 10'b0, rnd_ovf, rnd_sticky, 1'b0};
  assign rnd_flags  = rnd_no[2:0];

  typedef struct {
    logic [2:0]   rm;
    logic [2:0]   frm;
    logic [W-1:0] no;
    logic         ovf;
    logic         sticky;
    logic [15:0]  e_no;
    logic [2:0]   e_flags;
    logic         e_ill;
    logic [2:0]   e_rrm;
  } vec_t;

  typedef struct {
    logic        src;
    logic [15:0] no;
    logic [2:0]  flags;
    logic        ill;
  } exp_t;

  vec_t vt[7];
  exp_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  logic [2:0] m_acc;
  logic       m_last;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference from the rounding rules: dynamic mode, illegal modes, flag masking.
  function automatic exp_t predict(input logic src, input logic [2:0] rm, input logic [2:0] f,
                                   input logic [W-1:0] no, input logic ovf, input logic sticky);
    exp_t e;
    int   eff;
    logic [2:0] rr;
    eff     = (rm == 3'd7) ? int'(f) : int'(rm);
    e.ill   = (eff >= 5);
    rr      = e.ill ? 3'd0 : 3'(eff);
    e.src   = src;
    e.no    = no[W-1 -: 16] ^ {rr, 10'b0, ovf, sticky, 1'b0};
    e.flags = e.ill ? 3'b000 : no[2:0];
    return e;
  endfunction

  task automatic idle_inputs();
    req0_valid = 0; req0_no = '0; req0_rm = 0; req0_ovf = 0; req0_sticky = 0;
    req1_valid = 0; req1_no = '0; req1_rm = 0; req1_ovf = 0; req1_sticky = 0;
    frm = 0; out_ready = 0; fflags_clr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_l = 0;
    repeat (2) @(negedge clk);
    rst_l = 1;
    m_acc = 3'b000;
    m_last = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input logic clr, input string tag);
    @(negedge clk);
    frm = v.frm; req0_rm = v.rm; req0_no = v.no; req0_ovf = v.ovf; req0_sticky = v.sticky;
    req0_valid = 1; out_ready = 1;
    #1 chk({tag, ".ready"}, 32'(req0_ready), 1);
    @(negedge clk);
    req0_valid = 0;
    #1;
    chk({tag, ".rnd_rm"}, 32'(rnd_rm), 32'(v.e_rrm));
    chk({tag, ".rnd_no"}, 32'(rnd_no), 32'(v.no));
    chk({tag, ".vld_rnd"}, 32'(out_valid), 0);
    @(negedge clk);
    fflags_clr = clr;
    #1;
    chk({tag, ".vld"}, 32'(out_valid), 1);
    chk({tag, ".no"}, 32'(out_no), 32'(v.e_no));
    chk({tag, ".flags"}, 32'(out_flags), 32'(v.e_flags));
    chk({tag, ".ill"}, 32'(out_illegal), 32'(v.e_ill));
    chk({tag, ".src"}, 32'(out_src), 0);
    m_acc = clr ? v.e_flags : (m_acc | v.e_flags);
    @(negedge clk);
    fflags_clr = 0;
    #1;
    chk({tag, ".vld_after"}, 32'(out_valid), 0);
    chk({tag, ".acc"}, 32'(fflags_acc), 32'(m_acc));
  endtask

  initial begin
    vec_t va;
    vt[0] = '{3'b000, 3'b000, 28'h0000000, 1'b0, 1'b0, 16'h0000, 3'b000, 1'b0, 3'b000};
    vt[1] = '{3'b010, 3'b000, 28'hABCD123, 1'b0, 1'b0, 16'hEBCD, 3'b011, 1'b0, 3'b010};
    vt[2] = '{3'b111, 3'b001, 28'h12345F7, 1'b1, 1'b0, 16'h3230, 3'b111, 1'b0, 3'b001};
    vt[3] = '{3'b111, 3'b101, 28'h5555001, 1'b0, 1'b1, 16'h5557, 3'b000, 1'b1, 3'b000};
    vt[4] = '{3'b110, 3'b000, 28'h0F0F006, 1'b1, 1'b1, 16'h0F09, 3'b000, 1'b1, 3'b000};
    vt[5] = '{3'b100, 3'b111, 28'h8000004, 1'b0, 1'b0, 16'h0000, 3'b100, 1'b0, 3'b100};
    vt[6] = '{3'b111, 3'b011, 28'hFFFFFFA, 1'b0, 1'b0, 16'h9FFF, 3'b010, 1'b0, 3'b011};

    do_reset();
    #1;
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.out_no", 32'(out_no), 0);
    chk("rst.rnd_no", 32'(rnd_no), 0);
    chk("rst.acc", 32'(fflags_acc), 0);
    chk("rst.ready0", 32'(req0_ready), 0);

    for (int i = 0; i < 7; i++) run_vec(vt[i], 1'b0, $sformatf("vec%0d", i));

    // Tie after reset: req0 first, req1 taken on the OUT handshake; 5 cycles of back-pressure.
    do_reset();
    @(negedge clk);
    frm = 3'b001;
    req0_no = vt[1].no; req0_rm = vt[1].rm; req0_ovf = 0; req0_sticky = 0; req0_valid = 1;
    req1_no = vt[2].no; req1_rm = vt[2].rm; req1_ovf = 1; req1_sticky = 0; req1_valid = 1;
    out_ready = 1;
    #1 chk("tie.ready0", 32'(req0_ready), 1);
    chk("tie.ready1", 32'(req1_ready), 0);
    @(negedge clk);
    req0_valid = 0;
    #1 chk("tie.rnd_ready1", 32'(req1_ready), 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      out_ready = 0;
      #1;
      chk("bp.vld", 32'(out_valid), 1);
      chk("bp.no", 32'(out_no), 32'(vt[1].e_no));
      chk("bp.flags", 32'(out_flags), 32'(vt[1].e_flags));
      chk("bp.src", 32'(out_src), 0);
      chk("bp.readies", 32'({req0_ready, req1_ready}), 0);
    end
    @(negedge clk);
    out_ready = 1;
    #1 chk("tie.ready1_on_hs", 32'(req1_ready), 1);
    @(negedge clk);
    req1_valid = 0;
    #1 chk("tie.rnd_gap", 32'(out_valid), 0);
    chk("tie.rnd_rm1", 32'(rnd_rm), 3'b001);
    @(negedge clk);
    #1 chk("tie.src1", 32'(out_src), 1);
    chk("tie.no1", 32'(out_no), 32'(vt[2].e_no));
    @(negedge clk);
    #1 chk("tie.no_dup", 32'(out_valid), 0);

    // Accumulator: 001 then 100 gives 101; clear together with a 010 handshake leaves 010.
    do_reset();
    va = vt[0]; va.no = 28'h0000001; va.e_flags = 3'b001;
    run_vec(va, 1'b0, "acc_a");
    va.no = 28'h0000004; va.e_flags = 3'b100;
    run_vec(va, 1'b0, "acc_b");
    chk("acc_101", 32'(fflags_acc), 3'b101);
    va.no = 28'h0000002; va.e_flags = 3'b010;
    run_vec(va, 1'b1, "acc_c");
    chk("acc_clr_010", 32'(fflags_acc), 3'b010);

    // Reset while in RND after a req1 grant.
    @(negedge clk);
    req1_no = 28'hCAFE005; req1_rm = 0; req1_valid = 1;
    #1 chk("mid.ready1", 32'(req1_ready), 1);
    @(negedge clk);
    req1_valid = 0;
    #1 rst_l = 0;
    #1;
    chk("mid.out_valid", 32'(out_valid), 0);
    chk("mid.acc", 32'(fflags_acc), 0);
    chk("mid.rnd_no", 32'(rnd_no), 0);
    @(negedge clk);
    rst_l = 1;
    req0_valid = 1; req1_valid = 1;
    #1 chk("mid.tie0", 32'(req0_ready), 1);
    chk("mid.tie1", 32'(req1_ready), 0);

    // Randomized traffic against the scoreboard.
    do_reset();
    begin
      logic        vld[2];
      logic [2:0]  prm[2];
      logic [W-1:0] pno[2];
      logic        povf[2], pst[2];
      int          wcnt[2];
      int          lat;
      logic        hold;
      logic [15:0] h_no;
      logic [2:0]  h_fl;
      logic        rdy[2];
      exp_t        e;
      vld[0] = 0; vld[1] = 0; wcnt[0] = 0; wcnt[1] = 0; lat = 0; hold = 0;
      h_no = 0; h_fl = 0;
      for (int c = 0; c < 700; c++) begin
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
          if (!vld[s] && c < 650 && $urandom_range(0, 2) != 0) begin
            vld[s]  = 1;
            prm[s]  = 3'($urandom_range(0, 7));
            pno[s]  = 28'($urandom);
            povf[s] = 1'($urandom_range(0, 1));
            pst[s]  = 1'($urandom_range(0, 1));
            wcnt[s] = 0;
          end
        end
        if ($urandom_range(0, 3) == 0) frm = 3'($urandom_range(0, 7));
        out_ready  = (c >= 650) ? 1'b1 : 1'($urandom_range(0, 1));
        fflags_clr = ($urandom_range(0, 9) == 0);
        req0_valid = vld[0]; req0_rm = prm[0]; req0_no = pno[0]; req0_ovf = povf[0]; req0_sticky = pst[0];
        req1_valid = vld[1]; req1_rm = prm[1]; req1_no = pno[1]; req1_ovf = povf[1]; req1_sticky = pst[1];
        #1;
        chk("rnd.acc", 32'(fflags_acc), 32'(m_acc));
        if (req0_ready && req1_ready) chk("rnd.both_ready", 1, 0);
        if (lat == 2) begin chk("rnd.lat2", 32'(out_valid), 1); lat = 0; end
        if (lat == 1) begin chk("rnd.lat1", 32'(out_valid), 0); lat = 2; end
        if (hold) begin
          chk("rnd.hold_no", 32'(out_no), 32'(h_no));
          chk("rnd.hold_fl", 32'(out_flags), 32'(h_fl));
        end
        if (out_valid && out_ready) begin
          if (sbq.size() == 0) chk("rnd.spurious", 1, 0);
          else begin
            e = sbq.pop_front();
            chk("rnd.src", 32'(out_src), 32'(e.src));
            chk("rnd.no", 32'(out_no), 32'(e.no));
            chk("rnd.flags", 32'(out_flags), 32'(e.flags));
            chk("rnd.ill", 32'(out_illegal), 32'(e.ill));
            m_acc = fflags_clr ? e.flags : (m_acc | e.flags);
          end
        end else if (fflags_clr) m_acc = 3'b000;
        hold = out_valid && !out_ready;
        h_no = out_no; h_fl = out_flags;
        rdy[0] = req0_ready; rdy[1] = req1_ready;
        for (int s = 0; s < 2; s++) begin
          if (vld[s] && rdy[s]) begin
            if (vld[0] && vld[1]) chk("rnd.rr", 32'(s), 32'(!m_last));
            sbq.push_back(predict(1'(s), prm[s], frm, pno[s], povf[s], pst[s]));
            m_last = 1'(s);
            vld[s] = 0;
            lat = 1;
          end else if (vld[s]) begin
            wcnt[s]++;
            if (wcnt[s] == 40) chk($sformatf("rnd.starve%0d", s), 32'(wcnt[s]), 0);
          end
        end
      end
      chk("rnd.drained", 32'(sbq.size()), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
